i2s_encoder_multi: RTL and testbench

- Parametrised successor to the team's fixed 16-bit stereo I2S encoder.
- Serialises one stereo sample pair per frame onto o_lrclk/o_sdata, driven directly by the bit clock.
- Configurable sample width and slot width.
- Runtime-selectable framing: I2S, left-justified or right-justified, plus a mute control.
- Sits between the sample source (which reloads its data on o_latch) and an external DAC's serial input.

---
 rtl/i2s_encoder_multi.sv | 126 ++++++++++++
 tb/tb_i2s_encoder_multi.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_encoder_multi.sv
// i2s_encoder_multi
//   Serialises one stereo sample pair per frame (2*SLOT_W bit clocks) onto
//   o_lrclk/o_sdata. All state moves on the falling edge of i_bclk so the
//   DAC can sample on the rising edge.
// Ports:
//   i_bclk    bit clock (state updates on falling edge)
//   i_rst_x   asynchronous active-low reset
//   i_data_l  left sample, two's complement, DATA_W bits
//   i_data_r  right sample, DATA_W bits
//   i_mode    0 = I2S, 1 = left-justified, 2 = right-justified, 3 = I2S
//   i_mute    capture zeros instead of the samples
//   o_lrclk   word select
//   o_sdata   serial data, MSB first
//   o_latch   one-bclk pulse on the sample capture edge
module i2s_encoder_multi #(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 16
) (
  input  logic              i_bclk,
  input  logic              i_rst_x,
  input  logic [DATA_W-1:0] i_data_l,
  input  logic [DATA_W-1:0] i_data_r,
  input  logic [1:0]        i_mode,
  input  logic              i_mute,
  output logic              o_lrclk,
  output logic              o_sdata,
  output logic              o_latch
);

  localparam int F  = 2 * SLOT_W;
  localparam int CW = $clog2(F);

  localparam logic [CW-1:0]     C_LAST = CW'(F - 1);
  localparam logic [CW-1:0]     C_SLOT = CW'(SLOT_W);
  localparam logic [CW-1:0]     C_DATA = CW'(DATA_W);
  localparam logic [CW:0]       C_OFF  = (CW + 1)'(SLOT_W - DATA_W);
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_I2S     = 2'd0,
    MODE_LJ      = 2'd1,
    MODE_RJ      = 2'd2,
    MODE_I2S_ALT = 2'd3
  } mode_t;

  logic [CW-1:0]     c_q;
  logic [DATA_W-1:0] shadow_l_q;
  logic [DATA_W-1:0] shadow_r_q;
  mode_t             mode_q;
  logic              dly_q;

  logic              boundary;
  logic [CW-1:0]     c_nx;
  mode_t             mode_nx;
  logic [DATA_W-1:0] shadow_l_nx;
  logic [DATA_W-1:0] shadow_r_nx;
  logic              left_nx;
  logic [CW-1:0]     p_nx;
  logic [DATA_W-1:0] word_nx;
  logic [CW:0]       rj_diff;
  logic [CW-1:0]     shamt;
  logic              bit_valid;
  logic              bit_nx;
  logic              i2s_nx;
  logic              lrclk_nx;
  logic              sdata_nx;

  // Everything below describes the state after the coming edge, so the
  // outputs can be registered without adding a cycle of latency.
  always_comb begin
    boundary    = (c_q == C_LAST);
    c_nx        = boundary ? '0 : c_q + 1'b1;
    mode_nx     = boundary ? mode_t'(i_mode) : mode_q;
    shadow_l_nx = shadow_l_q;
    shadow_r_nx = shadow_r_q;
    if (boundary) begin
      shadow_l_nx = i_mute ? '0 : i_data_l;
      shadow_r_nx = i_mute ? '0 : i_data_r;
    end

    left_nx = (c_nx < C_SLOT);
    p_nx    = left_nx ? c_nx : c_nx - C_SLOT;
    word_nx = left_nx ? shadow_l_nx : shadow_r_nx;

    // RJ offsets the slot position by SLOT_W-DATA_W; the extra bit of the
    // subtraction doubles as the "before the data starts" flag.
    rj_diff = {1'b0, p_nx} - C_OFF;
    if (mode_nx == MODE_RJ) begin
      bit_valid = ~rj_diff[CW];
      shamt     = rj_diff[CW-1:0];
    end else begin
      bit_valid = (p_nx < C_DATA);
      shamt     = p_nx;
    end
    bit_nx = bit_valid & (|((word_nx << shamt) & MSB_MASK));

    i2s_nx   = (mode_nx == MODE_I2S) || (mode_nx == MODE_I2S_ALT);
    lrclk_nx = i2s_nx ? ~left_nx : left_nx;
    // In I2S the delay flop still holds the previous frame's last bit at
    // c = 0, so it crosses the capture edge untouched.
    sdata_nx = i2s_nx ? dly_q : bit_nx;
  end

  always_ff @(negedge i_bclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      c_q        <= C_LAST;
      shadow_l_q <= '0;
      shadow_r_q <= '0;
      mode_q     <= MODE_I2S;
      dly_q      <= 1'b0;
      o_lrclk    <= 1'b0;
      o_sdata    <= 1'b0;
      o_latch    <= 1'b0;
    end else begin
      c_q        <= c_nx;
      shadow_l_q <= shadow_l_nx;
      shadow_r_q <= shadow_r_nx;
      mode_q     <= mode_nx;
      dly_q      <= bit_nx;
      o_lrclk    <= lrclk_nx;
      o_sdata    <= sdata_nx;
      o_latch    <= boundary;
    end
  end

endmodule

// File: tb/tb_i2s_encoder_multi.sv
// tb_i2s_encoder_multi
//   Drives two encoder instances (16/16 and 16/24 slot geometry) from a
//   shared bit clock and reset. A frame-level reference builds each frame
//   as one packed word (left slot, right slot) and derives every output
//   bit from it; literal frame patterns pin that reference.
module tb_i2s_encoder_multi;

  logic bclk  = 1'b1;
  logic rst_x = 1'b1;

  logic [1:0][15:0] dl;
  logic [1:0][15:0] dr;
  logic [1:0][1:0]  md;
  logic [1:0]       mu;

  logic lr0, sd0, la0;
  logic lr1, sd1, la1;

  int tests  = 0;
  int failed = 0;

  int          cm[2];
  logic [63:0] cur_frame[2];
  logic [1:0]  mreg[2];
  logic        prev_last[2];
  logic [63:0] rec_sd[2];
  logic [63:0] rec_lr[2];
  logic [63:0] last_sd[2];
  logic [63:0] last_lr[2];
  int          frames[2];

  i2s_encoder_multi #(.DATA_W(16), .SLOT_W(16)) dut0 (
    .i_bclk(bclk), .i_rst_x(rst_x), .i_data_l(dl[0]), .i_data_r(dr[0]),
    .i_mode(md[0]), .i_mute(mu[0]), .o_lrclk(lr0), .o_sdata(sd0), .o_latch(la0)
  );

  i2s_encoder_multi #(.DATA_W(16), .SLOT_W(24)) dut1 (
    .i_bclk(bclk), .i_rst_x(rst_x), .i_data_l(dl[1]), .i_data_r(dr[1]),
    .i_mode(md[1]), .i_mute(mu[1]), .o_lrclk(lr1), .o_sdata(sd1), .o_latch(la1)
  );

  always #5 bclk = ~bclk;

  function automatic int sw_of(input int k);
    return (k == 0) ? 16 : 24;
  endfunction

  function automatic int f_of(input int k);
    return 2 * sw_of(k);
  endfunction

  // Frame word: left slot in the upper SLOT_W bits, right slot below.
  // LJ/I2S place the sample at the top of its slot, RJ at the bottom.
  function automatic logic [63:0] build(input int sw, input logic [1:0] m,
                                        input logic [15:0] l, input logic [15:0] r);
    logic [63:0] sl;
    logic [63:0] sr;
    sl = {48'd0, l};
    sr = {48'd0, r};
    if (m != 2'd2) begin
      sl = sl << (sw - 16);
      sr = sr << (sw - 16);
    end
    return (sl << sw) | sr;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    cm[k]        = f_of(k) - 1;
    cur_frame[k] = '0;
    mreg[k]      = 2'd0;
    prev_last[k] = 1'b0;
  endtask

  // Reference model and per-cycle compare.
  initial begin
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      frames[k] = 0;
      rec_sd[k] = '0;
      rec_lr[k] = '0;
    end
    forever begin
      @(negedge bclk or negedge rst_x);
      for (int k = 0; k < 2; k++) begin
        if (!rst_x) begin
          model_reset(k);
        end else begin
          cm[k] = (cm[k] + 1) % f_of(k);
          if (cm[k] == 0) begin
            prev_last[k] = cur_frame[k][0];
            cur_frame[k] = build(sw_of(k), md[k], mu[k] ? 16'd0 : dl[k], mu[k] ? 16'd0 : dr[k]);
            mreg[k]      = md[k];
          end
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        logic a_lr, a_sd, a_la;
        logic e_lr, e_sd, e_la;
        logic i2s;
        int   f, s;
        f    = f_of(k);
        s    = sw_of(k);
        a_lr = (k == 0) ? lr0 : lr1;
        a_sd = (k == 0) ? sd0 : sd1;
        a_la = (k == 0) ? la0 : la1;
        if (!rst_x) begin
          e_lr = 1'b0;
          e_sd = 1'b0;
          e_la = 1'b0;
        end else begin
          i2s  = (mreg[k] == 2'd0) || (mreg[k] == 2'd3);
          e_lr = i2s ? (cm[k] >= s) : (cm[k] < s);
          if (!i2s)
            e_sd = cur_frame[k][f - 1 - cm[k]];
          else if (cm[k] == 0)
            e_sd = prev_last[k];
          else
            e_sd = cur_frame[k][f - cm[k]];
          e_la = (cm[k] == 0);
        end
        check($sformatf("dut%0d lrclk c=%0d", k, cm[k]), {63'd0, a_lr}, {63'd0, e_lr});
        check($sformatf("dut%0d sdata c=%0d", k, cm[k]), {63'd0, a_sd}, {63'd0, e_sd});
        check($sformatf("dut%0d latch c=%0d", k, cm[k]), {63'd0, a_la}, {63'd0, e_la});
        if (rst_x) begin
          rec_sd[k][f - 1 - cm[k]] = a_sd;
          rec_lr[k][f - 1 - cm[k]] = a_lr;
          if (cm[k] == f - 1) begin
            last_sd[k] = rec_sd[k];
            last_lr[k] = rec_lr[k];
            frames[k]++;
          end
        end
      end
    end
  end

  task automatic wait_frames(input int k, input int target);
    for (int i = 0; i < 400 && frames[k] < target; i++) @(posedge bclk);
    if (frames[k] < target) begin
      tests++;
      failed++;
      $display("FAIL dut%0d frame wait: actual=%0d required=%0d", k, frames[k], target);
    end
  endtask

  task automatic wait_c(input int k, input int v);
    int i;
    i = 0;
    @(posedge bclk);
    while (cm[k] != v && i < 100) begin
      @(posedge bclk);
      i++;
    end
    if (cm[k] != v) begin
      tests++;
      failed++;
      $display("FAIL dut%0d wait for c: actual=%0d required=%0d", k, cm[k], v);
    end
  endtask

  initial begin
    int n;
    int k;
    dl[0] = 16'hF0F0; dr[0] = 16'h0F0F; md[0] = 2'd0; mu[0] = 1'b0;
    dl[1] = 16'hA5A5; dr[1] = 16'h8001; md[1] = 2'd1; mu[1] = 1'b0;

    #1 rst_x = 1'b0;
    #1;
    check("reset lrclk0", {63'd0, lr0}, 64'd0);
    check("reset sdata0", {63'd0, sd0}, 64'd0);
    check("reset latch0", {63'd0, la0}, 64'd0);
    repeat (4) @(posedge bclk);
    rst_x = 1'b1;
    @(negedge bclk);
    #1;
    check("first latch dut0", {63'd0, la0}, 64'd1);
    check("first latch dut1", {63'd0, la1}, 64'd1);

    // I2S default geometry and LJ with a wider slot.
    wait_frames(0, 2);
    wait_frames(1, 1);
    check("i2s frame sdata", last_sd[0], 64'hF8780787);
    check("i2s frame lrclk", last_lr[0], 64'h0000FFFF);
    check("lj24 frame sdata", last_sd[1], 64'hA5A500800100);
    check("lj24 frame lrclk", last_lr[1], 64'hFFFFFF000000);

    // RJ with a wider slot.
    md[1] = 2'd2;
    dl[1] = 16'hFFFF;
    n = frames[1];
    wait_frames(1, n + 2);
    check("rj24 frame sdata", last_sd[1], 64'h00FFFF008001);
    check("rj24 frame lrclk", last_lr[1], 64'hFFFFFF000000);

    // Mid-frame input changes only land at the next boundary.
    wait_c(0, 10);
    dl[0] = 16'h1234;
    md[0] = 2'd1;
    mu[0] = 1'b1;
    n = frames[0];
    wait_frames(0, n + 1);
    check("midframe keep sdata", last_sd[0], 64'hF8780787);
    check("midframe keep lrclk", last_lr[0], 64'h0000FFFF);
    wait_frames(0, n + 2);
    check("muted lj sdata", last_sd[0], 64'h0);
    check("muted lj lrclk", last_lr[0], 64'hFFFF0000);

    // Randomised inputs and mode switches.
    repeat (16) begin
      k = int'($urandom_range(0, 1));
      repeat ($urandom_range(1, 60)) @(posedge bclk);
      md[k] = 2'($urandom_range(0, 3));
      mu[k] = ($urandom_range(0, 3) == 0);
      dl[k] = 16'($urandom);
      dr[k] = 16'($urandom);
    end
    wait_frames(1, frames[1] + 1);

    // Asynchronous reset between edges in the middle of a frame.
    wait_c(0, 10);
    #2 rst_x = 1'b0;
    #1;
    check("async rst lrclk0", {63'd0, lr0}, 64'd0);
    check("async rst sdata0", {63'd0, sd0}, 64'd0);
    check("async rst latch0", {63'd0, la0}, 64'd0);
    dl[0] = 16'hF0F0; dr[0] = 16'h0F0F; md[0] = 2'd0; mu[0] = 1'b0;
    repeat (3) @(posedge bclk);
    rst_x = 1'b1;
    @(negedge bclk);
    #1;
    check("restart latch dut0", {63'd0, la0}, 64'd1);
    check("restart latch dut1", {63'd0, la1}, 64'd1);
    n = frames[0];
    wait_frames(0, n + 2);
    check("restart i2s sdata", last_sd[0], 64'hF8780787);
    check("restart i2s lrclk", last_lr[0], 64'h0000FFFF);

    repeat (8) begin
      k = int'($urandom_range(0, 1));
      repeat ($urandom_range(1, 50)) @(posedge bclk);
      md[k] = 2'($urandom_range(0, 3));
      mu[k] = ($urandom_range(0, 4) == 0);
      dl[k] = 16'($urandom);
      dr[k] = 16'($urandom);
    end
    wait_frames(0, frames[0] + 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
